// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Two-requester round-robin arbiter that funnels byte packets into a single
// downstream FIFO write port. A requester keeps the grant until it hands over
// a beat flagged `last` or has moved MAX_BURST beats, whichever comes first.
// The next owner is chosen in the same cycle the current owner releases, so
// back-to-back grants carry no idle bubble.
//
// Parameters
//   MAX_BURST   beats per grant before forced release (legal range 1..8)
//
// Ports
//   sys_clk     clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   req0_valid  requester 0 presents a byte
//   req0_data   requester 0 byte
//   req0_last   requester 0 final byte of a packet
//   req0_ready  requester 0 byte accepted this cycle (when valid)
//   req1_*      same as req0_* for requester 1
//   fifo_f      downstream FIFO full, stalls the current grant
//   tx_ready    FIFO write strobe, one byte per high cycle
//   tx_data     byte written when tx_ready is high (8'h00 with no grant)
//   grant       one-hot owner: 01 = req0, 10 = req1, 00 = none
//   cnt0/cnt1   per-requester accepted-beat counters, wrapping 16 bit
//               (present only when ARB_STATS_EN is defined)
//
// Build option
//   ARB_STATS_EN  adds the cnt0/cnt1 statistics outputs and counters.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       fifo_f,
    output logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [1:0] grant
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Counter value at which the beat being accepted is the final one of
    // the burst (counter holds beats already taken under this grant).
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    // 0 = req0 was served last, 1 = req1 was served last.
    logic       last_srv_q, last_srv_d;

    logic gnt0, gnt1;
    logic acc0, acc1;
    logic beat_acc;
    logic beat_last;
    logic rel;

    // Round-robin pick: the preferred requester wins when valid, otherwise
    // the other one, otherwise nobody.
    function automatic state_t arb_pick(input logic pref1,
                                        input logic v0,
                                        input logic v1);
        state_t s;
        if (pref1) s = v1 ? GNT1 : (v0 ? GNT0 : IDLE);
        else       s = v0 ? GNT0 : (v1 ? GNT1 : IDLE);
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Datapath / handshake, all combinational from the current state
    // ------------------------------------------------------------------
    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    assign grant = {gnt1, gnt0};

    assign req0_ready = gnt0 && !fifo_f;
    assign req1_ready = gnt1 && !fifo_f;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    assign beat_acc  = acc0 || acc1;
    assign beat_last = gnt1 ? req1_last : req0_last;

    assign tx_ready = beat_acc;
    assign tx_data  = gnt0 ? req0_data :
                      gnt1 ? req1_data : 8'h00;

    // Release only happens on an accepted beat; a stall (fifo_f) or a
    // valid gap leaves the grant and counter untouched.
    assign rel = beat_acc && (beat_last || (beat_cnt_q == BURST_LAST));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_srv_d = last_srv_q;

        case (state_q)
            IDLE: begin
                state_d    = arb_pick(!last_srv_q, req0_valid, req1_valid);
                beat_cnt_d = 4'd0;
            end
            GNT0, GNT1: begin
                if (rel) begin
                    // The releasing requester becomes last-served, so the
                    // other side is preferred for the hand-over decision.
                    last_srv_d = gnt1;
                    state_d    = arb_pick(gnt0, req0_valid, req1_valid);
                    // Cleared even if the same requester is re-granted so
                    // the new grant gets a full burst.
                    beat_cnt_d = 4'd0;
                end else if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= 4'd0;
            last_srv_q <= 1'b1;   // req0 wins the first contention
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_srv_q <= last_srv_d;
        end
    end

`ifdef ARB_STATS_EN
    // ------------------------------------------------------------------
    // Accepted-beat statistics, free-running wrap at 16 bits
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else begin
            if (acc0) cnt0 <= cnt0 + 16'h0001;
            if (acc1) cnt1 <= cnt1 + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Two arbiters (MAX_BURST = 4 and MAX_BURST = 1) share one set of requester
// inputs. A per-instance reference model tracks the owner, beats taken and
// last-served requester from the arbitration rules, and every cycle the
// grant, ready, strobe and data outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       r0v, r0l, r1v, r1l, fifo_f;
    logic [7:0] r0d, r1d;

    logic [1:0]       r0rdy, r1rdy, txr;
    logic [1:0][7:0]  txd;
    logic [1:0][1:0]  gnt;
`ifdef ARB_STATS_EN
    logic [1:0][15:0] c0, c1;
`endif

    fifo_wr_arbiter #(.MAX_BURST(4)) dut_b4 (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(r0rdy[0]),
        .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(r1rdy[0]),
        .fifo_f(fifo_f), .tx_ready(txr[0]), .tx_data(txd[0]), .grant(gnt[0])
`ifdef ARB_STATS_EN
        , .cnt0(c0[0]), .cnt1(c1[0])
`endif
    );

    fifo_wr_arbiter #(.MAX_BURST(1)) dut_b1 (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(r0rdy[1]),
        .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(r1rdy[1]),
        .fifo_f(fifo_f), .tx_ready(txr[1]), .tx_data(txd[1]), .grant(gnt[1])
`ifdef ARB_STATS_EN
        , .cnt0(c0[1]), .cnt1(c1[1])
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner -1/0/1, beats taken in the current grant,
    // last-served requester and per-requester accepted totals.
    // ------------------------------------------------------------------
    int burst [2] = '{4, 1};
    int m_own [2];
    int m_beats [2];
    int m_ls [2];
    int m_cnt0 [2];
    int m_cnt1 [2];

    function automatic int arb(input int pref, input bit v0, input bit v1);
        bit vv [2];
        vv[0] = v0;
        vv[1] = v1;
        if (vv[pref])     return pref;
        if (vv[1 - pref]) return 1 - pref;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]   = -1;
            m_beats[k] = 0;
            m_ls[k]    = 1;
            m_cnt0[k]  = 0;
            m_cnt1[k]  = 0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_grant_b%0d", tag, burst[k]), 16'(gnt[k]), 16'h0);
            chk($sformatf("%s_txr_b%0d", tag, burst[k]), 16'(txr[k]), 16'h0);
            chk($sformatf("%s_rdy_b%0d", tag, burst[k]), 16'({r1rdy[k], r0rdy[k]}), 16'h0);
`ifdef ARB_STATS_EN
            chk($sformatf("%s_cnt0_b%0d", tag, burst[k]), c0[k], 16'h0);
            chk($sformatf("%s_cnt1_b%0d", tag, burst[k]), c1[k], 16'h0);
`endif
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare the
    // combinational outputs against the model, then advance the model on
    // the rising edge.
    task automatic step(input bit v0, input logic [7:0] d0, input bit l0,
                        input bit v1, input logic [7:0] d1, input bit l1,
                        input bit ff);
        bit         vv [2];
        bit         ll [2];
        logic [7:0] dd [2];
        bit         acc [2];
        int         own;
        logic [1:0] e_gnt;
        @(negedge sys_clk);
        r0v = v0; r0d = d0; r0l = l0;
        r1v = v1; r1d = d1; r1l = l1;
        fifo_f = ff;
        vv[0] = v0; vv[1] = v1;
        ll[0] = l0; ll[1] = l1;
        dd[0] = d0; dd[1] = d1;
        #1;
        for (int k = 0; k < 2; k++) begin
            own    = m_own[k];
            e_gnt  = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
            acc[k] = (own >= 0) && vv[own] && !ff;
            chk($sformatf("grant_b%0d", burst[k]), 16'(gnt[k]), 16'(e_gnt));
            chk($sformatf("r0rdy_b%0d", burst[k]), 16'(r0rdy[k]), 16'((own == 0) && !ff));
            chk($sformatf("r1rdy_b%0d", burst[k]), 16'(r1rdy[k]), 16'((own == 1) && !ff));
            chk($sformatf("txr_b%0d", burst[k]), 16'(txr[k]), 16'(acc[k]));
            chk($sformatf("txd_b%0d", burst[k]), 16'(txd[k]), 16'((own >= 0) ? dd[own] : 8'h00));
`ifdef ARB_STATS_EN
            chk($sformatf("cnt0_b%0d", burst[k]), c0[k], 16'(m_cnt0[k]));
            chk($sformatf("cnt1_b%0d", burst[k]), c1[k], 16'(m_cnt1[k]));
`endif
        end
        @(posedge sys_clk);
        for (int k = 0; k < 2; k++) begin
            own = m_own[k];
            if (own < 0) begin
                m_own[k]   = arb(1 - m_ls[k], v0, v1);
                m_beats[k] = 0;
            end else if (acc[k]) begin
                m_beats[k]++;
                if (own == 0) m_cnt0[k] = (m_cnt0[k] + 1) % 65536;
                else          m_cnt1[k] = (m_cnt1[k] + 1) % 65536;
                if (ll[own] || m_beats[k] == burst[k]) begin
                    m_ls[k]    = own;
                    m_own[k]   = arb(1 - own, v0, v1);
                    m_beats[k] = 0;
                end
            end
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        r0v = 0; r0d = 8'h00; r0l = 0;
        r1v = 0; r1d = 8'h00; r1l = 0;
        fifo_f = 0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge sys_clk);
        rst_n = 1'b1;

        // Single requester, 3-byte packet.
        step(1, 8'h11, 0, 0, 8'h00, 0, 0);
        step(1, 8'h11, 0, 0, 8'h00, 0, 0);
        step(1, 8'h22, 0, 0, 8'h00, 0, 0);
        step(1, 8'h33, 1, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Contention from idle with 2-byte packets each.
        reset_pulse();
        step(1, 8'hA1, 0, 1, 8'hB1, 0, 0);
        step(1, 8'hA1, 0, 1, 8'hB1, 0, 0);
        step(1, 8'hA2, 1, 1, 8'hB1, 0, 0);
        step(0, 8'h00, 0, 1, 8'hB1, 0, 0);
        step(0, 8'h00, 0, 1, 8'hB2, 1, 0);
        step(0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Long req0 stream against a waiting req1, then a full-flag stall.
        for (int i = 0; i < 12; i++)
            step(1, 8'(8'h40 + i), 0, 1, 8'(8'h80 + i), (i % 3) == 2, 0);
        for (int i = 0; i < 3; i++)
            step(1, 8'h55, 0, 1, 8'h66, 0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 8'h57, 0, 1, 8'h68, 0, 0);

        // Randomized traffic with valid gaps, stalls and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                reset_pulse();
            end else begin
                step(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(5) == 0),
                     ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(5) == 0),
                     ($urandom_range(4) == 0));
            end
        end

        // Reset mid-packet, then contention must go to req0 first.
        step(0, 8'h00, 0, 1, 8'hC1, 0, 0);
        step(0, 8'h00, 0, 1, 8'hC2, 0, 0);
        reset_pulse();
        step(1, 8'hD1, 1, 1, 8'hE1, 1, 0);
        step(1, 8'hD1, 1, 1, 8'hE1, 1, 0);
        step(0, 8'h00, 0, 1, 8'hE1, 1, 0);
        step(0, 8'h00, 0, 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
